parte3_deinterleaver: RTL and testbench
=======================================

Name: parte3_deinterleaver

Overview:
- Receive end of the two-lane serial link: takes the single serial line produced by the 2:1 lane interleaver and rebuilds the two parallel lane words.
- Detects frame start, steers alternating bits to lane 0 / lane 1, checks the stop bit, and presents both words on a valid/ready handshake.
- Sits between the serial link input and the downstream consumer of the lane words.

Parameters:
- WORD_W, 8, bits per lane per frame; each frame carries 2*WORD_W data bits.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- bitEn  input  1  bit strobe; the line is sampled only on cycles with bitEn=1
- dataIn  input  1  serial line; idles high
- dataReady  input  1  consumer accepts the current words
- clrErr  input  1  clears the sticky overrun flag
- dataOut0  output  WORD_W  lane 0 word
- dataOut1  output  WORD_W  lane 1 word
- dataValid  output  1  dataOut0/dataOut1 hold an unconsumed frame
- frameErr  output  1  one-cycle pulse on a bad stop bit
- overrun  output  1  sticky: a good frame was dropped because the buffer was full

Behaviour:
- Frame format on bitEn samples:
  - start bit 0;
  - 2*WORD_W data bits, LSB first, interleaved lane0 bit0, lane1 bit0, lane0 bit1, and so on;
  - [parity bit, see Optional Feature];
  - stop bit 1.
- Reset: state IDLE; dataOut0=dataOut1=0; dataValid=frameErr=overrun=0; bit counter and lane shift registers 0. Reset mid-frame discards the partial frame.
- State machine:
  - IDLE: on bitEn with dataIn=0, go to DATA with cnt=0. dataIn=1 stays in IDLE.
  - DATA: on each bitEn, shift dataIn into the MSB of shift register lane cnt[0] (right shift), then cnt++. The sample taken at cnt=2*WORD_W-1 moves to PAR (if enabled) or STOP.
  - STOP: on bitEn, always return to IDLE.
    - dataIn=1 is a good frame.
    - dataIn=0 pulses frameErr for 1 cycle and discards the frame.
    - A 0 stop bit is not treated as a new start bit; the next start needs a fresh 0 sample in IDLE.
- Cycles with bitEn=0: state, counter and shift registers hold.
- Output buffer is a single entry:
  - A good frame loads dataOut0/dataOut1 and sets dataValid on the clock edge that samples the stop bit. dataValid is visible 1 cycle after that sample.
  - The load happens if dataValid=0, or if dataValid=1 and dataReady=1 in the same cycle. Simultaneous consume and load leaves dataValid=1 with the new words.
  - Otherwise the frame is dropped, overrun is set to 1, and the old words are kept.
- Handshake:
  - Transfer occurs when dataValid and dataReady are both 1; dataValid clears on the next cycle unless a simultaneous load occurs.
  - dataOut0/dataOut1 stay stable while dataValid=1.
  - dataReady while dataValid=0 is ignored.
- overrun:
  - cleared by clrErr=1;
  - if clrErr and a new overrun occur in the same cycle, overrun=1 (set wins).
- frameErr is never sticky.

Optional Feature:
- Macro: PARTE3_PARITY_EN.
- Defined:
  - Adds state PAR between DATA and STOP; one bitEn sample carries even parity over all 2*WORD_W data bits.
  - Adds output port parityErr (1 bit, reset 0), pulsed for 1 cycle when the stop bit is sampled (good or bad) on a frame whose parity mismatched.
  - A parity-mismatched frame is discarded: no load, no overrun.
- Not defined: no PAR state, no parityErr port; frame is start, data, stop.

Test Plan:
- Reset, then bitEn=1 every cycle, frame lane0=0xA5, lane1=0x3C, good stop, dataReady=0 -> dataValid=1 one cycle after the stop sample; dataOut0=0xA5, dataOut1=0x3C; frameErr=0.
- Same frame with stop bit 0 -> frameErr high exactly 1 cycle, dataValid stays 0, FSM back in IDLE; a following good frame 0x01/0x80 is received correctly.
- Two good frames (0x11/0x22 then 0x33/0x44) with dataReady=0 -> outputs stay 0x11/0x22, overrun=1; clrErr pulse -> overrun=0.
- dataReady=1 in the same cycle the second frame's stop bit is sampled -> dataValid remains 1, outputs 0x33/0x44, overrun=0.
- bitEn=1 only every 4th cycle, frame 0xFF/0x00 -> identical result to the continuous case; assert rst mid-DATA -> all outputs 0, the partial frame is never presented.
- PARTE3_PARITY_EN defined: frame 0xA5/0x3C with a wrong parity bit -> parityErr pulses once, dataValid=0; with correct parity (0) -> normal load.

Source files
------------

// File: rtl/parte3_deinterleaver.sv
// Serial 2-lane deinterleaver: start/data/stop framing, one-entry output buffer.
// Optional even-parity bit between data and stop when PARTE3_PARITY_EN is defined.
module parte3_deinterleaver #(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bitEn,
    input  logic              dataIn,
    input  logic              dataReady,
    input  logic              clrErr,
`ifdef PARTE3_PARITY_EN
    output logic              parityErr,
`endif
    output logic [WORD_W-1:0] dataOut0,
    output logic [WORD_W-1:0] dataOut1,
    output logic              dataValid,
    output logic              frameErr,
    output logic              overrun
);
    localparam int CW = $clog2(2 * WORD_W);
    localparam logic [CW-1:0] LAST = CW'(2 * WORD_W - 1);

`ifdef PARTE3_PARITY_EN
    typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
`endif

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WORD_W-1:0] sh0_q, sh0_d;
    logic [WORD_W-1:0] sh1_q, sh1_d;
    logic [WORD_W-1:0] out0_q, out0_d;
    logic [WORD_W-1:0] out1_q, out1_d;
    logic              valid_q, valid_d;
    logic              ferr_q, ferr_d;
    logic              ovr_q, ovr_d;
    logic              good;
`ifdef PARTE3_PARITY_EN
    logic              par_q, par_d;
    logic              perr_q, perr_d;
    logic              perr_out_q, perr_out_d;
`endif

    // Next-state: framing FSM, lane steering and output buffer control
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh0_d   = sh0_q;
        sh1_d   = sh1_q;
        out0_d  = out0_q;
        out1_d  = out1_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        ovr_d   = ovr_q;
        good    = 1'b0;
`ifdef PARTE3_PARITY_EN
        par_d      = par_q;
        perr_d     = perr_q;
        perr_out_d = 1'b0;
`endif
        if (valid_q && dataReady) valid_d = 1'b0;
        if (clrErr) ovr_d = 1'b0;
        if (bitEn) begin
            unique case (state_q)
                IDLE: begin
                    if (!dataIn) begin
                        state_d = DATA;
                        cnt_d   = '0;
`ifdef PARTE3_PARITY_EN
                        par_d   = 1'b0;
                        perr_d  = 1'b0;
`endif
                    end
                end
                DATA: begin
                    if (!cnt_q[0]) sh0_d = {dataIn, sh0_q[WORD_W-1:1]};
                    else           sh1_d = {dataIn, sh1_q[WORD_W-1:1]};
                    cnt_d = cnt_q + 1'b1;
`ifdef PARTE3_PARITY_EN
                    par_d = par_q ^ dataIn;
                    if (cnt_q == LAST) state_d = PAR;
`else
                    if (cnt_q == LAST) state_d = STOP;
`endif
                end
`ifdef PARTE3_PARITY_EN
                PAR: begin
                    perr_d  = par_q ^ dataIn;
                    state_d = STOP;
                end
`endif
                STOP: begin
                    state_d = IDLE;
                    ferr_d  = !dataIn;
`ifdef PARTE3_PARITY_EN
                    perr_out_d = perr_q;
                    good       = dataIn && !perr_q;
`else
                    good       = dataIn;
`endif
                end
                default: state_d = IDLE;
            endcase
        end
        // Load when the buffer is free or being drained this cycle
        if (good) begin
            if (!valid_q || dataReady) begin
                out0_d  = sh0_q;
                out1_d  = sh1_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh0_q   <= '0;
            sh1_q   <= '0;
            out0_q  <= '0;
            out1_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef PARTE3_PARITY_EN
            par_q      <= 1'b0;
            perr_q     <= 1'b0;
            perr_out_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh0_q   <= sh0_d;
            sh1_q   <= sh1_d;
            out0_q  <= out0_d;
            out1_q  <= out1_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
`ifdef PARTE3_PARITY_EN
            par_q      <= par_d;
            perr_q     <= perr_d;
            perr_out_q <= perr_out_d;
`endif
        end
    end

    assign dataOut0  = out0_q;
    assign dataOut1  = out1_q;
    assign dataValid = valid_q;
    assign frameErr  = ferr_q;
    assign overrun   = ovr_q;
`ifdef PARTE3_PARITY_EN
    assign parityErr = perr_out_q;
`endif

endmodule

// File: tb/tb_parte3_deinterleaver.sv
// Directed bench for parte3_deinterleaver.
// Covers PARTE3_PARITY_EN cases when that macro is defined.
module tb_parte3_deinterleaver;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         bitEn = 1'b0;
    logic         dataIn = 1'b1;
    logic         dataReady = 1'b0;
    logic         clrErr = 1'b0;
    logic [W-1:0] dataOut0;
    logic [W-1:0] dataOut1;
    logic         dataValid;
    logic         frameErr;
    logic         overrun;
`ifdef PARTE3_PARITY_EN
    logic         parityErr;
`endif

    int checks = 0;
    int errors = 0;

    parte3_deinterleaver #(.WORD_W(W)) dut (
        .clk(clk),
        .rst(rst),
        .bitEn(bitEn),
        .dataIn(dataIn),
        .dataReady(dataReady),
        .clrErr(clrErr),
`ifdef PARTE3_PARITY_EN
        .parityErr(parityErr),
`endif
        .dataOut0(dataOut0),
        .dataOut1(dataOut1),
        .dataValid(dataValid),
        .frameErr(frameErr),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bitEn  = 1'b0;
            dataIn = 1'b1;
        end
    endtask

    // gap-1 idle cycles, then one strobed sample of b
    task automatic send_bit(input logic b, input int gap);
        repeat (gap - 1) begin
            @(negedge clk);
            bitEn  = 1'b0;
            dataIn = 1'b1;
        end
        @(negedge clk);
        bitEn  = 1'b1;
        dataIn = b;
    endtask

    // start bit, interleaved data and (if enabled) parity; no stop bit
    task automatic send_body(input logic [W-1:0] w0, input logic [W-1:0] w1,
                             input logic par, input int gap);
        send_bit(1'b0, gap);
        for (int i = 0; i < W; i++) begin
            send_bit(w0[i], gap);
            send_bit(w1[i], gap);
        end
`ifdef PARTE3_PARITY_EN
        send_bit(par, gap);
`else
        if (par === 1'bx) idle(0);
`endif
    endtask

    task automatic good_frame(input logic [W-1:0] w0, input logic [W-1:0] w1,
                              input int gap);
        send_body(w0, w1, ^{w0, w1}, gap);
        send_bit(1'b1, gap);
        idle(1);
    endtask

    task automatic consume();
        dataReady = 1'b1;
        idle(1);
        dataReady = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        chk("rst_valid", 32'(dataValid), 32'h0);
        chk("rst_out0", 32'(dataOut0), 32'h0);
        chk("rst_out1", 32'(dataOut1), 32'h0);
        chk("rst_ferr", 32'(frameErr), 32'h0);
        chk("rst_ovr", 32'(overrun), 32'h0);

        // basic good frame
        send_body(8'hA5, 8'h3C, 1'b0, 1);
        send_bit(1'b1, 1);
        chk("pre_stop_valid", 32'(dataValid), 32'h0);
        idle(1);
        chk("a5_valid", 32'(dataValid), 32'h1);
        chk("a5_out0", 32'(dataOut0), 32'hA5);
        chk("a5_out1", 32'(dataOut1), 32'h3C);
        chk("a5_ferr", 32'(frameErr), 32'h0);
        idle(2);
        chk("a5_hold", 32'(dataOut0), 32'hA5);
        consume();
        chk("a5_consumed", 32'(dataValid), 32'h0);

        // bad stop bit, then recovery
        send_body(8'hA5, 8'h3C, 1'b0, 1);
        send_bit(1'b0, 1);
        idle(1);
        chk("bad_ferr", 32'(frameErr), 32'h1);
        chk("bad_valid", 32'(dataValid), 32'h0);
        idle(1);
        chk("bad_ferr_pulse", 32'(frameErr), 32'h0);
        good_frame(8'h01, 8'h80, 1);
        chk("rec_valid", 32'(dataValid), 32'h1);
        chk("rec_out0", 32'(dataOut0), 32'h01);
        chk("rec_out1", 32'(dataOut1), 32'h80);
        consume();

        // overrun
        good_frame(8'h11, 8'h22, 1);
        good_frame(8'h33, 8'h44, 1);
        chk("ovr_valid", 32'(dataValid), 32'h1);
        chk("ovr_out0", 32'(dataOut0), 32'h11);
        chk("ovr_out1", 32'(dataOut1), 32'h22);
        chk("ovr_flag", 32'(overrun), 32'h1);
        idle(2);
        chk("ovr_sticky", 32'(overrun), 32'h1);
        clrErr = 1'b1;
        idle(1);
        clrErr = 1'b0;
        chk("ovr_clr", 32'(overrun), 32'h0);
        consume();
        chk("ovr_consumed", 32'(dataValid), 32'h0);

        // consume and load in the same cycle
        good_frame(8'h11, 8'h22, 1);
        send_body(8'h33, 8'h44, 1'b0, 1);
        send_bit(1'b1, 1);
        dataReady = 1'b1;
        idle(1);
        dataReady = 1'b0;
        chk("sim_valid", 32'(dataValid), 32'h1);
        chk("sim_out0", 32'(dataOut0), 32'h33);
        chk("sim_out1", 32'(dataOut1), 32'h44);
        chk("sim_ovr", 32'(overrun), 32'h0);
        consume();
        chk("sim_consumed", 32'(dataValid), 32'h0);

        // sparse bit strobe
        good_frame(8'hFF, 8'h00, 4);
        chk("gap_valid", 32'(dataValid), 32'h1);
        chk("gap_out0", 32'(dataOut0), 32'hFF);
        chk("gap_out1", 32'(dataOut1), 32'h00);

        // reset mid-frame
        send_bit(1'b0, 1);
        for (int i = 0; i < 5; i++) send_bit(1'b0, 1);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        chk("mid_rst_valid", 32'(dataValid), 32'h0);
        chk("mid_rst_out0", 32'(dataOut0), 32'h0);
        chk("mid_rst_out1", 32'(dataOut1), 32'h0);
        for (int i = 0; i < 14; i++) send_bit(1'b1, 1);
        idle(2);
        chk("mid_rst_nopres", 32'(dataValid), 32'h0);
        good_frame(8'h5A, 8'hC3, 1);
        chk("post_rst_out0", 32'(dataOut0), 32'h5A);
        chk("post_rst_out1", 32'(dataOut1), 32'hC3);
        consume();

`ifdef PARTE3_PARITY_EN
        send_body(8'hA5, 8'h3C, 1'b1, 1);
        send_bit(1'b1, 1);
        idle(1);
        chk("perr_pulse", 32'(parityErr), 32'h1);
        chk("perr_valid", 32'(dataValid), 32'h0);
        chk("perr_ovr", 32'(overrun), 32'h0);
        idle(1);
        chk("perr_once", 32'(parityErr), 32'h0);
        send_body(8'hA5, 8'h3C, 1'b0, 1);
        send_bit(1'b1, 1);
        idle(1);
        chk("pok_perr", 32'(parityErr), 32'h0);
        chk("pok_valid", 32'(dataValid), 32'h1);
        chk("pok_out0", 32'(dataOut0), 32'hA5);
        chk("pok_out1", 32'(dataOut1), 32'h3C);
        consume();
`endif

        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
